// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the iterative multiply sequencer.
// Latency: none (declarations only).
// Backpressure: none; optional upper-half support is selected by the MUL_HIGH_EN macro.
package mul_seq_pkg;

  // Controller states: waiting, iterating, presenting the product
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // One shift-add iteration per operand bit
  localparam int MUL_ITER = 32;

  // Encodings of the product-half select
  localparam logic MUL_LO = 1'b0;
  localparam logic MUL_HI = 1'b1;

endpackage

// File: rtl/mul_shift_add_step.sv
// One iteration of the shift-add multiplier: conditional add followed by a shift.
// Latency: purely combinational.
// Backpressure: none; the sequencer decides when the step result is registered.
// With MUL_HIGH_EN the pair {hi, lo} is a 2*XLEN product register shifted right;
// without it, hi is a left-shift accumulator and lo is the right-shifted multiplier.
module mul_shift_add_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] mcand,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] mcand_nxt,
  output logic [XLEN-1:0] hi_nxt,
  output logic [XLEN-1:0] lo_nxt
);

  logic [XLEN-1:0] addend;

  // The multiplier bit under inspection always sits in lo[0]
  assign addend = lo[0] ? mcand : '0;

`ifdef MUL_HIGH_EN
  logic [XLEN:0] sum;

  // Carry-out of the add becomes the new top bit as {c, hi, lo} shifts right
  assign sum       = {1'b0, hi} + {1'b0, addend};
  assign hi_nxt    = sum[XLEN:1];
  assign lo_nxt    = {sum[0], lo[XLEN-1:1]};
  assign mcand_nxt = mcand;
`else
  // Low half only: accumulate the shifted multiplicand, carries past XLEN are dropped
  assign hi_nxt    = hi + addend;
  assign lo_nxt    = {1'b0, lo[XLEN-1:1]};
  assign mcand_nxt = {mcand[XLEN-2:0], 1'b0};
`endif

endmodule

// File: rtl/mul_sequencer.sv
// EX-stage multi-cycle multiply controller driving the shift-add step datapath.
// Latency: start accepted in N, BUSY N+1..N+XLEN, done pulse with result in N+XLEN+1.
// Backpressure: stall holds the front of the pipeline; flush aborts; MUL_HIGH_EN adds MULHU.
module mul_sequencer
  import mul_seq_pkg::*;
#(
  parameter int XLEN = MUL_ITER
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            sel_hi,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  mul_state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  mcand;
  logic [XLEN-1:0]  prod_hi;
  logic [XLEN-1:0]  prod_lo;
  logic [XLEN-1:0]  mcand_step;
  logic [XLEN-1:0]  hi_step;
  logic [XLEN-1:0]  lo_step;
  logic             load;
  logic             iterate;

  mul_shift_add_step #(
    .XLEN (XLEN)
  ) u_step (
    .mcand     (mcand),
    .hi        (prod_hi),
    .lo        (prod_lo),
    .mcand_nxt (mcand_step),
    .hi_nxt    (hi_step),
    .lo_nxt    (lo_step)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and outputs; flush outranks both start and iteration completion
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    iterate   = 1'b0;
    stall     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !flush && !rst) begin
          load      = 1'b1;
          stall     = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        busy  = 1'b1;
        stall = 1'b1;
        if (flush) begin
          state_nxt = IDLE;
        end else begin
          iterate = 1'b1;
          if (cnt == LAST_ITER) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        // A start still high here belongs to the instruction now leaving EX
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand load, per-iteration datapath update and iteration counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      mcand   <= '0;
      prod_hi <= '0;
      prod_lo <= '0;
    end else if (load) begin
      cnt     <= '0;
      mcand   <= op_a;
      prod_hi <= '0;
      prod_lo <= op_b;
    end else if (iterate) begin
      cnt     <= cnt + CNT_W'(1);
      mcand   <= mcand_step;
      prod_hi <= hi_step;
      prod_lo <= lo_step;
    end
  end

`ifdef MUL_HIGH_EN
  logic sel_hi_q;

  // Half select is captured with the operands so it stays stable while iterating
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_hi_q <= MUL_LO;
    end else if (load) begin
      sel_hi_q <= sel_hi;
    end
  end

  assign result = (sel_hi_q == MUL_HI) ? prod_hi : prod_lo;
`else
  // Low-half-only build: the accumulator holds the product, sel_hi has no effect
  logic unused_sel_hi;
  assign unused_sel_hi = sel_hi;
  assign result        = prod_hi;
`endif

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: timeline-based reference model plus directed cases.
// Latency: expects the product XLEN+1 cycles after the accepting cycle.
// Backpressure: stall/busy/done are compared every cycle; MUL_HIGH_EN selects MULHU expectations.
module tb_mul_sequencer;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            start;
  logic            flush;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            sel_hi;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  mul_sequencer #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .flush  (flush),
    .op_a   (op_a),
    .op_b   (op_b),
    .sel_hi (sel_hi),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Product as plain arithmetic, then pick the half the build can return
  function automatic logic [XLEN-1:0] model_product(input logic [XLEN-1:0] a,
                                                    input logic [XLEN-1:0] b,
                                                    input logic s);
    logic [2*XLEN-1:0] p;
    p = (2*XLEN)'(a) * (2*XLEN)'(b);
`ifdef MUL_HIGH_EN
    return s ? p[2*XLEN-1:XLEN] : p[XLEN-1:0];
`else
    return p[XLEN-1:0];
`endif
  endfunction

  // Reference model: age of the accepted multiply in cycles (0 = nothing in flight)
  int              age = 0;
  logic [XLEN-1:0] m_pend = '0;
  logic [XLEN-1:0] m_res = '0;
  bit              m_known = 0;

  always @(posedge clk) begin
    if (rst) begin
      age     = 0;
      m_res   = '0;
      m_known = 1;
    end else if (age == 0) begin
      if (start && !flush) begin
        age     = 1;
        m_pend  = model_product(op_a, op_b, sel_hi);
        m_known = 0;
      end
    end else if (age <= XLEN) begin
      if (flush) begin
        age = 0;
      end else begin
        age++;
        if (age == XLEN + 1) m_res = m_pend;
      end
    end else begin
      age     = 0;
      m_known = 1;
    end
  end

  // Compare every cycle, half a clock after the edge
  always @(negedge clk) begin
    if (chk_en) begin
      logic e_busy, e_done, e_stall;
      e_busy  = (age >= 1) && (age <= XLEN);
      e_done  = (age == XLEN + 1);
      e_stall = e_busy || (age == 0 && start && !flush && !rst);
      chk("model_stall", 64'(stall), 64'(e_stall));
      chk("model_busy", 64'(busy), 64'(e_busy));
      chk("model_done", 64'(done), 64'(e_done));
      if (e_done || (age == 0 && m_known))
        chk("model_result", 64'(result), 64'(m_res));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One full multiply with literal expectations on latency, stall length and result
  task automatic run_mul(input string tag, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic s, input logic [XLEN-1:0] exp_res);
    int lat;
    int stl;
    bit seen;
    op_a = a; op_b = b; sel_hi = s; start = 1'b1; flush = 1'b0;
    @(negedge clk);
    chk({tag, "_stall_accept"}, 64'(stall), 64'd1);
    stl  = stall ? 1 : 0;
    lat  = 0;
    seen = 0;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        lat  = i;
        chk({tag, "_result"}, 64'(result), 64'(exp_res));
        chk({tag, "_stall_done"}, 64'(stall), 64'd0);
        break;
      end
      if (stall) stl++;
      tick();
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_latency"}, 64'(lat), 64'(XLEN + 1));
    chk({tag, "_stall_cycles"}, 64'(stl), 64'(XLEN + 1));
    tick();
    @(negedge clk);
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    chk({tag, "_result_held"}, 64'(result), 64'(exp_res));
    tick();
  endtask

  initial begin
    bit seen;
    int dones;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op_a = '0; op_b = '0; sel_hi = 1'b0;
    tick();
    chk_en = 1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_stall", 64'(stall), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    tick();

    run_mul("mul_3x5", 32'd3, 32'd5, 1'b0, 32'd15);
    run_mul("ones_lo", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001);
`ifdef MUL_HIGH_EN
    run_mul("ones_hi", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE);
`else
    run_mul("ones_hi", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001);
`endif

    // Flush in the tenth BUSY cycle
    op_a = 32'd123; op_b = 32'd456; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_stall", 64'(stall), 64'd0);
    chk("flush_busy", 64'(busy), 64'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dones++;
      tick();
    end
    chk("flush_no_done", 64'(dones), 64'd0);
    run_mul("mul_7x6", 32'd7, 32'd6, 1'b0, 32'd42);

    // Reset in the middle of BUSY
    op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_stall", 64'(stall), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    tick();
    run_mul("mul_2p16sq", 32'h0001_0000, 32'h0001_0000, 1'b0, 32'd0);
`ifdef MUL_HIGH_EN
    run_mul("mul_2p16sq_hi", 32'h0001_0000, 32'h0001_0000, 1'b1, 32'd1);
`endif

    // Start held through DONE: ignored there, re-accepted in the next IDLE cycle
    op_a = 32'd9; op_b = 32'd9; start = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        chk("hold_stall_in_done", 64'(stall), 64'd0);
        break;
      end
      tick();
    end
    chk("hold_done_seen", 64'(seen), 64'd1);
    tick();
    @(negedge clk);
    chk("hold_reaccept_stall", 64'(stall), 64'd1);
    chk("hold_reaccept_busy", 64'(busy), 64'd0);
    tick();
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        chk("hold_second_result", 64'(result), 64'd81);
        break;
      end
      tick();
    end
    chk("hold_second_done_seen", 64'(seen), 64'd1);
    tick();
    tick();

    // Start and flush together in IDLE
    start = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("startflush_stall", 64'(stall), 64'd0);
    tick();
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("startflush_busy", 64'(busy), 64'd0);
    tick();

    // Random traffic, covered by the per-cycle model compare
    for (int i = 0; i < 4000; i++) begin
      start  = ($urandom_range(0, 3) == 0);
      flush  = ($urandom_range(0, 39) == 0);
      rst    = ($urandom_range(0, 599) == 0);
      sel_hi = 1'($urandom_range(0, 1));
      op_a   = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom();
      op_b   = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom();
      if ($urandom_range(0, 9) == 0) op_b = 32'($urandom_range(0, 15));
      tick();
    end
    start = 1'b0; flush = 1'b0; rst = 1'b0;
    for (int i = 0; i < 40; i++) tick();

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
